// File: rtl/rob_recovery_ctrl_pkg.sv
// Shared types and constants for the ROB branch-recovery controller.
// The ROB pointer width is fixed here so the checkpoint entry type can live in
// the package; older-masks are sized for the largest supported checkpoint count.
package rob_recovery_ctrl_pkg;

    localparam int NCHK_DEF  = 4;
    localparam int NCHK_MAX  = 8;
    localparam int ROB_PTR_W = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RECOVER = 2'd1,
        HOLD    = 2'd2
    } rcv_state_e;

    typedef struct packed {
        logic                  live;
        logic [ROB_PTR_W-1:0]  tail;
        logic [ROB_PTR_W:0]    used;
        logic [NCHK_MAX-1:0]   older_mask;
    } chk_entry_t;

endpackage

// File: rtl/rob_recovery_ctrl_rcv_chk_alloc.sv
// Priority free-slot finder: reports whether any checkpoint is free and the
// lowest free index (0 when none is free).
module rcv_chk_alloc #(
    parameter int NCHK  = 4,
    parameter int CHK_W = $clog2(NCHK)
) (
    input  logic [NCHK-1:0]  free_i,
    output logic             any_free_o,
    output logic [CHK_W-1:0] id_o
);

    // Scan from the top down so the lowest free index wins.
    always_comb begin
        any_free_o = 1'b0;
        id_o       = '0;
        for (int i = NCHK - 1; i >= 0; i--) begin
            if (free_i[i]) begin
                any_free_o = 1'b1;
                id_o       = CHK_W'(i);
            end
        end
    end

endmodule

// File: rtl/rob_recovery_ctrl.sv
// ROB recovery controller: allocates branch checkpoints holding ROB tail/used
// snapshots, squashes younger checkpoints on a mispredict, pulses recover_o with
// the snapshot and stalls dispatch for HOLD_CYC further cycles.
// Optional feature macro: ROB_RCV_STATS_EN adds mispredict and stall-cycle counters.
module rob_recovery_ctrl
    import rob_recovery_ctrl_pkg::*;
#(
    parameter int NCHK     = NCHK_DEF,
    parameter int HOLD_CYC = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    chk_alloc_valid_i,
    output logic                    chk_alloc_ready_o,
    output logic [$clog2(NCHK)-1:0] chk_alloc_id_o,
    input  logic [ROB_PTR_W-1:0]    rob_tail_i,
    input  logic [ROB_PTR_W:0]      rob_used_i,
    input  logic                    resolve_valid_i,
    input  logic [$clog2(NCHK)-1:0] resolve_chk_id_i,
    input  logic                    resolve_mispredict_i,
    input  logic                    commit_fire_i,
    output logic                    recover_o,
    output logic [ROB_PTR_W-1:0]    recover_tail_o,
    output logic [ROB_PTR_W:0]      recover_used_count_o,
    output logic                    dispatch_stall_o,
`ifdef ROB_RCV_STATS_EN
    output logic [31:0]             stat_mispredict_o,
    output logic [31:0]             stat_stall_cyc_o,
`endif
    output logic [NCHK-1:0]         chk_live_o
);

    localparam int CHK_W = $clog2(NCHK);
    localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYC - 1);

    chk_entry_t          chk_q [NCHK];
    rcv_state_e          state_q;
    logic [3:0]          hold_cnt_q;

    logic [NCHK_MAX-1:0] live_vec;
    logic [NCHK_MAX-1:0] freed;
    logic [NCHK_MAX-1:0] alloc_mask;
    logic [NCHK-1:0]     free_vec;
    logic                any_free;
    logic                res_hit;
    logic                mis_fire;
    logic                alloc_fire;
    chk_entry_t          snap;
    logic [ROB_PTR_W:0]  rcv_used;

    // Used-count decrement that stops at zero.
    function automatic logic [ROB_PTR_W:0] sat_dec(input logic [ROB_PTR_W:0] v, input logic en);
        return (en && (v != '0)) ? v - 1'b1 : v;
    endfunction

    // Gather live bits into one vector; upper bits beyond NCHK stay zero.
    always_comb begin
        live_vec = '0;
        for (int i = 0; i < NCHK; i++) begin
            live_vec[i] = chk_q[i].live;
        end
    end

    assign res_hit    = resolve_valid_i && live_vec[resolve_chk_id_i];
    assign mis_fire   = res_hit && resolve_mispredict_i;
    assign free_vec   = ~live_vec[NCHK-1:0];
    assign chk_live_o = live_vec[NCHK-1:0];

    // Checkpoints released this cycle: the resolved one, plus every younger one on a mispredict.
    always_comb begin
        freed = '0;
        if (res_hit) begin
            freed[resolve_chk_id_i] = 1'b1;
        end
        if (mis_fire) begin
            for (int k = 0; k < NCHK; k++) begin
                if (chk_q[k].live && chk_q[k].older_mask[resolve_chk_id_i]) begin
                    freed[k] = 1'b1;
                end
            end
        end
    end

    assign alloc_mask = live_vec & ~freed;
    assign snap       = chk_q[resolve_chk_id_i];
    assign rcv_used   = sat_dec(snap.used, commit_fire_i);

    rcv_chk_alloc #(
        .NCHK  (NCHK),
        .CHK_W (CHK_W)
    ) u_chk_alloc (
        .free_i     (free_vec),
        .any_free_o (any_free),
        .id_o       (chk_alloc_id_o)
    );

    assign chk_alloc_ready_o = (state_q == IDLE) && any_free && !mis_fire;
    assign alloc_fire        = chk_alloc_valid_i && chk_alloc_ready_o;

    // Checkpoint table: allocate, release, track commits against each snapshot.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NCHK; i++) begin
                chk_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NCHK; i++) begin
                if (alloc_fire && (chk_alloc_id_o == CHK_W'(i))) begin
                    chk_q[i].live       <= 1'b1;
                    chk_q[i].tail       <= rob_tail_i;
                    chk_q[i].used       <= rob_used_i;
                    chk_q[i].older_mask <= alloc_mask;
                end else begin
                    chk_q[i].live       <= chk_q[i].live & ~freed[i];
                    chk_q[i].older_mask <= chk_q[i].older_mask & ~freed;
                    chk_q[i].used       <= sat_dec(chk_q[i].used, commit_fire_i && chk_q[i].live);
                end
            end
        end
    end

    // Recovery FSM with registered recover pulse, snapshot and stall outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q              <= IDLE;
            hold_cnt_q           <= '0;
            recover_o            <= 1'b0;
            recover_tail_o       <= '0;
            recover_used_count_o <= '0;
            dispatch_stall_o     <= 1'b0;
        end else if (mis_fire) begin
            state_q              <= RECOVER;
            hold_cnt_q           <= '0;
            recover_o            <= 1'b1;
            recover_tail_o       <= snap.tail;
            recover_used_count_o <= rcv_used;
            dispatch_stall_o     <= 1'b1;
        end else begin
            case (state_q)
                RECOVER: begin
                    recover_o  <= 1'b0;
                    hold_cnt_q <= '0;
                    if (HOLD_CYC > 0) begin
                        state_q          <= HOLD;
                        dispatch_stall_o <= 1'b1;
                    end else begin
                        state_q          <= IDLE;
                        dispatch_stall_o <= 1'b0;
                    end
                end
                HOLD: begin
                    recover_o <= 1'b0;
                    if (hold_cnt_q == HOLD_LAST) begin
                        state_q          <= IDLE;
                        dispatch_stall_o <= 1'b0;
                    end else begin
                        hold_cnt_q <= hold_cnt_q + 4'd1;
                    end
                end
                default: begin
                    state_q          <= IDLE;
                    recover_o        <= 1'b0;
                    dispatch_stall_o <= 1'b0;
                end
            endcase
        end
    end

`ifdef ROB_RCV_STATS_EN
    // Wrapping event counters: accepted mispredicts and stalled dispatch cycles.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stat_mispredict_o <= '0;
            stat_stall_cyc_o  <= '0;
        end else begin
            if (mis_fire) begin
                stat_mispredict_o <= stat_mispredict_o + 32'd1;
            end
            if (dispatch_stall_o) begin
                stat_stall_cyc_o <= stat_stall_cyc_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_rob_recovery_ctrl.sv
// Directed bench for rob_recovery_ctrl (NCHK=4, HOLD_CYC=2, ROB_PTR_W=4).
module tb_rob_recovery_ctrl;

    logic       clk_i;
    logic       rst_ni;
    logic       chk_alloc_valid_i;
    logic       chk_alloc_ready_o;
    logic [1:0] chk_alloc_id_o;
    logic [3:0] rob_tail_i;
    logic [4:0] rob_used_i;
    logic       resolve_valid_i;
    logic [1:0] resolve_chk_id_i;
    logic       resolve_mispredict_i;
    logic       commit_fire_i;
    logic       recover_o;
    logic [3:0] recover_tail_o;
    logic [4:0] recover_used_count_o;
    logic       dispatch_stall_o;
    logic [3:0] chk_live_o;
`ifdef ROB_RCV_STATS_EN
    logic [31:0] stat_mispredict_o;
    logic [31:0] stat_stall_cyc_o;
`endif

    int checks = 0;
    int passed = 0;

    rob_recovery_ctrl #(
        .NCHK     (4),
        .HOLD_CYC (2)
    ) dut (
        .clk_i                (clk_i),
        .rst_ni               (rst_ni),
        .chk_alloc_valid_i    (chk_alloc_valid_i),
        .chk_alloc_ready_o    (chk_alloc_ready_o),
        .chk_alloc_id_o       (chk_alloc_id_o),
        .rob_tail_i           (rob_tail_i),
        .rob_used_i           (rob_used_i),
        .resolve_valid_i      (resolve_valid_i),
        .resolve_chk_id_i     (resolve_chk_id_i),
        .resolve_mispredict_i (resolve_mispredict_i),
        .commit_fire_i        (commit_fire_i),
        .recover_o            (recover_o),
        .recover_tail_o       (recover_tail_o),
        .recover_used_count_o (recover_used_count_o),
        .dispatch_stall_o     (dispatch_stall_o),
`ifdef ROB_RCV_STATS_EN
        .stat_mispredict_o    (stat_mispredict_o),
        .stat_stall_cyc_o     (stat_stall_cyc_o),
`endif
        .chk_live_o           (chk_live_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_inputs();
        chk_alloc_valid_i    = 1'b0;
        rob_tail_i           = '0;
        rob_used_i           = '0;
        resolve_valid_i      = 1'b0;
        resolve_chk_id_i     = '0;
        resolve_mispredict_i = 1'b0;
        commit_fire_i        = 1'b0;
    endtask

    task automatic do_alloc(input logic [3:0] t, input logic [4:0] u);
        chk_alloc_valid_i = 1'b1;
        rob_tail_i        = t;
        rob_used_i        = u;
        tick();
        chk_alloc_valid_i = 1'b0;
    endtask

    task automatic do_resolve(input logic [1:0] id, input logic mis);
        resolve_valid_i      = 1'b1;
        resolve_chk_id_i     = id;
        resolve_mispredict_i = mis;
        tick();
        resolve_valid_i      = 1'b0;
        resolve_mispredict_i = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_ni = 1'b0;
        repeat (2) tick();
        checks++; if (recover_o !== 1'b0) $display("FAIL reset_recover got %0b want 0", recover_o); else passed++;
        checks++; if (recover_tail_o !== 4'd0) $display("FAIL reset_tail got %0d want 0", recover_tail_o); else passed++;
        checks++; if (recover_used_count_o !== 5'd0) $display("FAIL reset_used got %0d want 0", recover_used_count_o); else passed++;
        checks++; if (dispatch_stall_o !== 1'b0) $display("FAIL reset_stall got %0b want 0", dispatch_stall_o); else passed++;
        checks++; if (chk_live_o !== 4'b0000) $display("FAIL reset_live got %b want 0000", chk_live_o); else passed++;
        checks++; if (chk_alloc_id_o !== 2'd0) $display("FAIL reset_id got %0d want 0", chk_alloc_id_o); else passed++;
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick();
        checks++; if (chk_alloc_ready_o !== 1'b1) $display("FAIL reset_ready got %0b want 1", chk_alloc_ready_o); else passed++;
    endtask

    task automatic test_alloc();
        for (int i = 0; i < 4; i++) begin
            chk_alloc_valid_i = 1'b1;
            rob_tail_i        = 4'(3 + 2 * i);
            rob_used_i        = 5'(i + 1);
            #1;
            checks++; if (chk_alloc_id_o !== 2'(i)) $display("FAIL alloc_id[%0d] got %0d want %0d", i, chk_alloc_id_o, i); else passed++;
            tick();
        end
        chk_alloc_valid_i = 1'b0;
        #1;
        checks++; if (chk_live_o !== 4'b1111) $display("FAIL alloc_live got %b want 1111", chk_live_o); else passed++;
        checks++; if (chk_alloc_ready_o !== 1'b0) $display("FAIL alloc_full_ready got %0b want 0", chk_alloc_ready_o); else passed++;
    endtask

    task automatic test_mispredict_hold();
        int stall_cnt;
        int rcv_cnt;
        commit_fire_i = 1'b1;
        repeat (2) tick();
        commit_fire_i = 1'b0;
        do_resolve(2'd1, 1'b1);
        checks++; if (recover_o !== 1'b1) $display("FAIL mp_recover got %0b want 1", recover_o); else passed++;
        checks++; if (recover_tail_o !== 4'd5) $display("FAIL mp_tail got %0d want 5", recover_tail_o); else passed++;
        checks++; if (recover_used_count_o !== 5'd0) $display("FAIL mp_used got %0d want 0", recover_used_count_o); else passed++;
        checks++; if (chk_live_o !== 4'b0001) $display("FAIL mp_live got %b want 0001", chk_live_o); else passed++;
        stall_cnt = dispatch_stall_o ? 1 : 0;
        rcv_cnt   = recover_o ? 1 : 0;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (dispatch_stall_o) stall_cnt++;
            if (recover_o) rcv_cnt++;
        end
        checks++; if (stall_cnt != 3) $display("FAIL mp_stall_cycles got %0d want 3", stall_cnt); else passed++;
        checks++; if (rcv_cnt != 1) $display("FAIL mp_pulse_cycles got %0d want 1", rcv_cnt); else passed++;
        checks++; if (recover_tail_o !== 4'd5) $display("FAIL mp_tail_hold got %0d want 5", recover_tail_o); else passed++;
        checks++; if (chk_alloc_ready_o !== 1'b1) $display("FAIL mp_ready_after got %0b want 1", chk_alloc_ready_o); else passed++;
    endtask

    task automatic test_reuse();
        do_alloc(4'd4, 5'd2);
        do_alloc(4'd6, 5'd3);
        do_resolve(2'd0, 1'b0);
        checks++; if (chk_live_o !== 4'b0110) $display("FAIL reuse_live_after_ok got %b want 0110", chk_live_o); else passed++;
        checks++; if (recover_o !== 1'b0) $display("FAIL reuse_no_pulse got %0b want 0", recover_o); else passed++;
        chk_alloc_valid_i = 1'b1;
        rob_tail_i        = 4'd8;
        rob_used_i        = 5'd3;
        #1;
        checks++; if (chk_alloc_id_o !== 2'd0) $display("FAIL reuse_id got %0d want 0", chk_alloc_id_o); else passed++;
        tick();
        chk_alloc_valid_i = 1'b0;
        do_resolve(2'd0, 1'b1);
        checks++; if (recover_tail_o !== 4'd8) $display("FAIL reuse_mp0_tail got %0d want 8", recover_tail_o); else passed++;
        checks++; if (chk_live_o !== 4'b0110) $display("FAIL reuse_mp0_live got %b want 0110", chk_live_o); else passed++;
        do_resolve(2'd1, 1'b1);
        checks++; if (recover_o !== 1'b1) $display("FAIL reuse_mp1_recover got %0b want 1", recover_o); else passed++;
        checks++; if (recover_tail_o !== 4'd4) $display("FAIL reuse_mp1_tail got %0d want 4", recover_tail_o); else passed++;
        checks++; if (chk_live_o !== 4'b0000) $display("FAIL reuse_mp1_live got %b want 0000", chk_live_o); else passed++;
        repeat (3) tick();
        checks++; if (dispatch_stall_o !== 1'b0) $display("FAIL reuse_stall_end got %0b want 0", dispatch_stall_o); else passed++;
    endtask

    task automatic test_tail_wrap();
        do_alloc(4'd15, 5'd16);
        commit_fire_i        = 1'b1;
        chk_alloc_valid_i    = 1'b1;
        rob_tail_i           = 4'd2;
        rob_used_i           = 5'd1;
        resolve_valid_i      = 1'b1;
        resolve_chk_id_i     = 2'd0;
        resolve_mispredict_i = 1'b1;
        #1;
        checks++; if (chk_alloc_ready_o !== 1'b0) $display("FAIL wrap_ready got %0b want 0", chk_alloc_ready_o); else passed++;
        tick();
        clear_inputs();
        checks++; if (recover_tail_o !== 4'd15) $display("FAIL wrap_tail got %0d want 15", recover_tail_o); else passed++;
        checks++; if (recover_used_count_o !== 5'd15) $display("FAIL wrap_used got %0d want 15", recover_used_count_o); else passed++;
        checks++; if (chk_live_o !== 4'b0000) $display("FAIL wrap_live got %b want 0000", chk_live_o); else passed++;
        repeat (3) tick();
    endtask

    task automatic test_nested();
        do_alloc(4'd1, 5'd1);
        do_alloc(4'd2, 5'd2);
        do_alloc(4'd3, 5'd3);
        do_resolve(2'd2, 1'b1);
        checks++; if (recover_tail_o !== 4'd3) $display("FAIL nest_first_tail got %0d want 3", recover_tail_o); else passed++;
        checks++; if (chk_live_o !== 4'b0011) $display("FAIL nest_first_live got %b want 0011", chk_live_o); else passed++;
        tick();
        checks++; if (recover_o !== 1'b0 || dispatch_stall_o !== 1'b1) $display("FAIL nest_hold got rcv=%0b stall=%0b want rcv=0 stall=1", recover_o, dispatch_stall_o); else passed++;
        do_resolve(2'd0, 1'b1);
        checks++; if (recover_o !== 1'b1) $display("FAIL nest_second_pulse got %0b want 1", recover_o); else passed++;
        checks++; if (recover_tail_o !== 4'd1) $display("FAIL nest_second_tail got %0d want 1", recover_tail_o); else passed++;
        checks++; if (recover_used_count_o !== 5'd1) $display("FAIL nest_second_used got %0d want 1", recover_used_count_o); else passed++;
        checks++; if (chk_live_o !== 4'b0000) $display("FAIL nest_second_live got %b want 0000", chk_live_o); else passed++;
        repeat (3) tick();
        do_resolve(2'd3, 1'b1);
        checks++; if (recover_o !== 1'b0 || dispatch_stall_o !== 1'b0) $display("FAIL nonlive_ignored got rcv=%0b stall=%0b want 0 0", recover_o, dispatch_stall_o); else passed++;
        checks++; if (recover_tail_o !== 4'd1) $display("FAIL nonlive_tail_hold got %0d want 1", recover_tail_o); else passed++;
    endtask

    task automatic test_reset_mid_recover();
        do_alloc(4'd7, 5'd2);
        do_resolve(2'd0, 1'b1);
        checks++; if (recover_o !== 1'b1) $display("FAIL rst_pre_pulse got %0b want 1", recover_o); else passed++;
        rst_ni = 1'b0;
        #1;
        checks++; if (recover_o !== 1'b0 || dispatch_stall_o !== 1'b0) $display("FAIL rst_async_ctrl got rcv=%0b stall=%0b want 0 0", recover_o, dispatch_stall_o); else passed++;
        checks++; if (recover_tail_o !== 4'd0 || recover_used_count_o !== 5'd0) $display("FAIL rst_async_snap got tail=%0d used=%0d want 0 0", recover_tail_o, recover_used_count_o); else passed++;
        checks++; if (chk_live_o !== 4'b0000) $display("FAIL rst_async_live got %b want 0000", chk_live_o); else passed++;
`ifdef ROB_RCV_STATS_EN
        checks++; if (stat_mispredict_o !== 32'd0 || stat_stall_cyc_o !== 32'd0) $display("FAIL rst_stats got mp=%0d st=%0d want 0 0", stat_mispredict_o, stat_stall_cyc_o); else passed++;
`endif
        @(negedge clk_i);
        rst_ni = 1'b1;
        begin
            int rcv_cnt;
            rcv_cnt = 0;
            for (int c = 0; c < 4; c++) begin
                tick();
                if (recover_o || dispatch_stall_o) rcv_cnt++;
            end
            checks++; if (rcv_cnt != 0) $display("FAIL rst_no_pulse got %0d active cycles want 0", rcv_cnt); else passed++;
        end
        checks++; if (chk_alloc_ready_o !== 1'b1) $display("FAIL rst_ready got %0b want 1", chk_alloc_ready_o); else passed++;
    endtask

    initial begin
        test_reset();
        test_alloc();
        test_mispredict_hold();
        test_reuse();
        test_tail_wrap();
        test_nested();
        test_reset_mid_recover();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/rob_recovery_ctrl.md
ROB_RECOVERY_CTRL -- requirements
Module: rob_recovery_ctrl

Interface
REQ-001 SHALL have parameter NCHK, default 4, number of branch checkpoints (2..8).
REQ-002 SHALL have parameter HOLD_CYC, default 2, dispatch-stall cycles after a recover pulse (0..15).
REQ-003 SHALL have ports clk_i  in  1  clock; rst_ni  in  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 SHALL have ports chk_alloc_valid_i  in  1  branch dispatching; chk_alloc_ready_o  out  1  checkpoint available; chk_alloc_id_o  out  $clog2(NCHK)  granted checkpoint id.
REQ-005 SHALL have ports rob_tail_i  in  ROB_PTR_W  ROB tail after branch allocation; rob_used_i  in  ROB_PTR_W+1  ROB used count after branch allocation.
REQ-006 SHALL have ports resolve_valid_i  in  1; resolve_chk_id_i  in  $clog2(NCHK); resolve_mispredict_i  in  1  (branch outcome from WB).
REQ-007 SHALL have port commit_fire_i  in  1  ROB head popped this cycle.
REQ-008 SHALL have ports recover_o  out  1; recover_tail_o  out  ROB_PTR_W; recover_used_count_o  out  ROB_PTR_W+1  (drive ROB recover inputs).
REQ-009 SHALL have ports dispatch_stall_o  out  1; chk_live_o  out  NCHK  live-checkpoint bitmap.

Function
REQ-010 SHALL keep per checkpoint: live bit, tail, used count, older-mask (NCHK bits of checkpoints live at allocation).
REQ-011 chk_alloc_ready_o SHALL = state IDLE && any free checkpoint && !(resolve_valid_i && resolve_mispredict_i && target live).
REQ-012 Alloc fire SHALL pick lowest-index free checkpoint, latch rob_tail_i/rob_used_i, older-mask = live bits minus any freed this cycle, set live next cycle.
REQ-013 On commit_fire_i every live checkpoint's used SHALL decrement by 1 (saturate at 0); alloc-fire same cycle stores rob_used_i undecremented.
REQ-014 Correct resolve of live checkpoint j SHALL clear live[j] and bit j of all older-masks next cycle.
REQ-015 Mispredict resolve of live j SHALL free j and every checkpoint whose older-mask has bit j, register recover_tail_o=tail[j], recover_used_count_o=used[j] minus 1 if commit_fire_i same cycle, and enter RECOVER.
REQ-016 Resolve of a non-live id SHALL be ignored.
REQ-017 FSM: IDLE -> RECOVER (on mispredict); RECOVER -> HOLD (HOLD_CYC>0) else IDLE; HOLD counts HOLD_CYC cycles -> IDLE.
REQ-018 recover_o SHALL be 1 exactly in RECOVER (one cycle); recover_tail_o/used hold last value otherwise.
REQ-019 dispatch_stall_o SHALL be 1 in RECOVER and HOLD.
REQ-020 Resolves SHALL be accepted in all states; a mispredict on a still-live (older) checkpoint in RECOVER/HOLD SHALL restart at RECOVER with its snapshot.
REQ-021 Tail arithmetic SHALL wrap modulo 2**ROB_PTR_W; used width ROB_PTR_W+1, never above ROB depth.

Reset
REQ-022 rst_ni low SHALL asynchronously clear all live bits, masks, snapshots, counters; state IDLE.
REQ-023 Reset values: recover_o 0, recover_tail_o 0, recover_used_count_o 0, dispatch_stall_o 0, chk_live_o 0, chk_alloc_id_o 0, chk_alloc_ready_o 1 after deassertion.
REQ-024 Reset mid-RECOVER/HOLD SHALL abort to IDLE with no further recover pulse.

Configuration
REQ-025 With ROB_RCV_STATS_EN defined SHALL add outputs stat_mispredict_o (32b, count of REQ-015 events) and stat_stall_cyc_o (32b, cycles dispatch_stall_o=1), wrapping, reset 0.
REQ-026 Without ROB_RCV_STATS_EN those ports and counters SHALL not exist; behaviour otherwise identical.

Structure
REQ-027 buffer_pkgs SHALL hold rcv_state_e (IDLE, RECOVER, HOLD), chk_entry_t (live, tail, used, older_mask), NCHK_DEF.
REQ-028 Sub-module rcv_chk_alloc (priority free-slot finder, combinational) is natural; rest in one module.

Verification
REQ-029 Alloc 4 branches tail 3,5,7,9 used 1..4 -> ids 0,1,2,3, chk_alloc_ready_o 0 after 4th.
REQ-030 Mispredict id 1 after 2 commits -> recover_o 1 cycle, tail 5, used 0; live=0001; stall 3 cycles (HOLD_CYC=2).
REQ-031 Correct resolve id 0 then alloc -> id 0 reused, older-mask excludes old id 0.
REQ-032 Tail 15 snapshot (ROB_PTR_W=4), mispredict -> recover_tail_o 15, no wrap error; alloc during mispredict cycle refused.
REQ-033 Mispredict id 2 then during HOLD mispredict id 0 -> second recover pulse with id 0 snapshot, live=0.
REQ-034 rst_ni low in RECOVER -> outputs 0 immediately; with ROB_RCV_STATS_EN, stat counters 0.
